// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack processor operand stack.
package stack_pkg;

   localparam int STACK_DEFAULT_WIDTH = 16;
   localparam int STACK_DEFAULT_DEPTH = 16;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_PUSH    = 3'd1,
      OP_POP     = 3'd2,
      OP_DUP     = 3'd3,
      OP_SWAP    = 3'd4,
      OP_OVER    = 3'd5,
      OP_REPLACE = 3'd6,
      OP_PUSH2   = 3'd7
   } stack_op_t;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PUSH2_B = 1'b1
   } stack_state_t;

endpackage

// File: rtl/stack_if.sv
// Command/status bundle between the stack user (master) and stack_core (slave).
interface stack_if import stack_pkg::*; #(
   parameter int WIDTH = STACK_DEFAULT_WIDTH,
   parameter int DEPTH = STACK_DEFAULT_DEPTH
);
   logic                   op_valid;
   stack_op_t              op;
   logic [WIDTH-1:0]       getin;
   logic [WIDTH-1:0]       getin2;
   logic                   clr_err;
   logic                   op_ready;
   logic [WIDTH-1:0]       top_of_stack;
   logic [WIDTH-1:0]       second_of_stack;
   logic [$clog2(DEPTH):0] count;
   logic                   full;
   logic                   empty;
   logic                   err;

   modport master (
      output op_valid, op, getin, getin2, clr_err,
      input  op_ready, top_of_stack, second_of_stack, count, full, empty, err
   );

   modport slave (
      input  op_valid, op, getin, getin2, clr_err,
      output op_ready, top_of_stack, second_of_stack, count, full, empty, err
   );
endinterface

// File: rtl/stack_spill_ram.sv
// Spill storage for stack entries below top/second: one sync write, one async read.
module stack_spill_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                           CLK,
   input  logic                           i_we,
   input  logic [$clog2(DEPTH-2)-1:0]     i_waddr,
   input  logic [WIDTH-1:0]               i_wdata,
   input  logic [$clog2(DEPTH-2)-1:0]     i_raddr,
   output logic [WIDTH-1:0]               o_rdata
);
   // NOTE: memory arrays carry no reset; the entry count decides which words are meaningful.
   logic [WIDTH-1:0] r_mem [0:DEPTH-3];

   always_ff @(posedge CLK) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/stack_core.sv
// Operand stack: top/second in registers, deeper entries spilled to RAM.
// Optional sticky error flag: define STACK_ERR_STICKY_EN.
module stack_core import stack_pkg::*; #(
   parameter int WIDTH = STACK_DEFAULT_WIDTH,
   parameter int DEPTH = STACK_DEFAULT_DEPTH
) (
   input logic CLK,
   input logic reset,
   stack_if.slave bus
);
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int RAM_AW = $clog2(DEPTH - 2);
   localparam logic [CW-1:0] C_1     = CW'(1);
   localparam logic [CW-1:0] C_2     = CW'(2);
   localparam logic [CW-1:0] C_3     = CW'(3);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] C_DM2   = CW'(DEPTH - 2);

   stack_state_t      r_state;
   logic [WIDTH-1:0]  r_top, r_second, r_latch;
   logic [CW-1:0]     r_count;
   logic              r_full, r_empty, r_err, r_ready;

   stack_state_t      w_state_nx;
   logic [WIDTH-1:0]  w_top_nx, w_second_nx, w_latch_nx, w_push_val, w_rdata;
   logic [CW-1:0]     w_count_nx;
   logic              w_push, w_fault, w_we;
   logic [RAM_AW-1:0] w_waddr, w_raddr;

   assign w_waddr = (r_count >= C_2) ? RAM_AW'(r_count - C_2) : '0;
   assign w_raddr = (r_count >= C_3) ? RAM_AW'(r_count - C_3) : '0;

   stack_spill_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_spill (
      .CLK     (CLK),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (r_second),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nx  = ST_IDLE;
      w_top_nx    = r_top;
      w_second_nx = r_second;
      w_count_nx  = r_count;
      w_latch_nx  = r_latch;
      w_push      = 1'b0;
      w_push_val  = bus.getin;
      w_fault     = 1'b0;
      w_we        = 1'b0;

      if (r_state == ST_PUSH2_B) begin
         w_push     = 1'b1;
         w_push_val = r_latch;
      end else if (bus.op_valid && r_ready) begin
         unique case (bus.op)
            OP_PUSH:    if (r_count < C_DEPTH) w_push = 1'b1; else w_fault = 1'b1;
            OP_POP:
               if (r_count >= C_1) begin
                  w_top_nx    = r_second;
                  w_second_nx = (r_count >= C_3) ? w_rdata : '0;
                  w_count_nx  = r_count - C_1;
               end else w_fault = 1'b1;
            OP_DUP:
               if (r_count >= C_1 && r_count < C_DEPTH) begin
                  w_push     = 1'b1;
                  w_push_val = r_top;
               end else w_fault = 1'b1;
            OP_SWAP:
               if (r_count >= C_2) begin
                  w_top_nx    = r_second;
                  w_second_nx = r_top;
               end else w_fault = 1'b1;
            OP_OVER:
               if (r_count >= C_2 && r_count < C_DEPTH) begin
                  w_push     = 1'b1;
                  w_push_val = r_second;
               end else w_fault = 1'b1;
            OP_REPLACE: if (r_count >= C_1) w_top_nx = bus.getin; else w_fault = 1'b1;
            OP_PUSH2:
               // Room for both halves is checked up front so the second half cannot fault.
               if (r_count <= C_DM2) begin
                  w_push     = 1'b1;
                  w_latch_nx = bus.getin2;
                  w_state_nx = ST_PUSH2_B;
               end else w_fault = 1'b1;
            default: ;
         endcase
      end

      if (w_push) begin
         w_we        = (r_count >= C_2);
         w_second_nx = r_top;
         w_top_nx    = w_push_val;
         w_count_nx  = r_count + C_1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_top    <= '0;
         r_second <= '0;
         r_latch  <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_err    <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_state  <= w_state_nx;
         r_top    <= w_top_nx;
         r_second <= w_second_nx;
         r_latch  <= w_latch_nx;
         r_count  <= w_count_nx;
         r_full   <= (w_count_nx == C_DEPTH);
         r_empty  <= (w_count_nx == '0);
         r_ready  <= (w_state_nx == ST_IDLE);
`ifdef STACK_ERR_STICKY_EN
         r_err    <= w_fault | (r_err & ~bus.clr_err);
`else
         r_err    <= w_fault;
`endif
      end
   end

   assign bus.op_ready        = r_ready;
   assign bus.top_of_stack    = r_top;
   assign bus.second_of_stack = r_second;
   assign bus.count           = r_count;
   assign bus.full            = r_full;
   assign bus.empty           = r_empty;
   assign bus.err             = r_err;
endmodule

// File: doc/stack_core.md
# stack_core

Parametrised operand-stack datapath for the stack processor, successor to the fixed 16-bit stack inside `final_processor`. It holds top and second entries in registers and spills deeper entries into a RAM. It executes one stack operation per accepted command, including a two-cycle double push of `getin`/`getin2`. It flags overflow and underflow instead of corrupting state, and feeds the ALU and IO path through `top_of_stack`/`second_of_stack`.

## Interface
- `WIDTH`, 16, entry width in bits
- `DEPTH`, 16, maximum entries; power of two, at least 4
- `CLK` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `op_valid` in 1: command present
- `op` in 3: stack_op_t opcode
- `getin` in WIDTH: first data operand
- `getin2` in WIDTH: second data operand, used by PUSH2 only
- `clr_err` in 1: clears the sticky error flag; ignored without the macro
- `op_ready` out 1: command accepted this cycle when high together with `op_valid`
- `top_of_stack` out WIDTH: entry count-1, 0 when empty
- `second_of_stack` out WIDTH: entry count-2, 0 when count<2
- `count` out $clog2(DEPTH)+1: number of entries
- `full` out 1: count==DEPTH
- `empty` out 1: count==0
- `err` out 1: fault indication

## Operation
- Opcodes: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 REPLACE, 7 PUSH2.
- Storage:
  - `top` and `second` are registers.
  - Entry i for i<count-2 lives at spill RAM address i.
- On a push-type op (PUSH, DUP, OVER, PUSH2 halves):
  - the old `second` is written to RAM[count-2] when count>=2;
  - the old `top` moves to `second`.
- On POP:
  - `top` <= `second`;
  - `second` <= RAM[count-3] when count>=3, else 0;
  - count-1.
- Per-op behaviour:
  - PUSH: `top` <= getin.
  - DUP: `top` unchanged, count+1.
  - OVER: new `top` = old `second`, new `second` = old `top`.
  - SWAP: exchange `top` and `second`.
  - REPLACE: `top` <= getin, count unchanged.
  - PUSH2: cycle 1 acts as PUSH getin and latches getin2; cycle 2 acts as PUSH of the latched value. Final result is top=getin2, second=getin.
- Control FSM: IDLE and PUSH2_B.
  - IDLE -> PUSH2_B on an accepted, legal PUSH2.
  - PUSH2_B -> IDLE unconditionally.
  - `op_ready` is 0 in PUSH2_B; `op_valid` in that cycle is ignored and not queued.
- Legality; a faulting op leaves every register and the RAM unchanged and raises `err`:
  - PUSH: count<DEPTH
  - PUSH2: count<=DEPTH-2, checked entirely in cycle 1
  - POP: count>=1
  - DUP: 1<=count<DEPTH
  - SWAP: count>=2
  - OVER: 2<=count<DEPTH
  - REPLACE: count>=1
  - NOP: always legal
- `err` behaviour without the macro: high exactly one cycle after a faulting accepted op.
- No arithmetic; count saturates by legality rules, never wraps.

## Timing
- All outputs are registered; each op is visible the cycle after the accepting edge.
- Latency: 1 cycle for all ops. PUSH2 takes 2 cycles; its intermediate state (top=getin) is visible for one cycle.
- Async reset values:
  - count=0, top=0, second=0
  - empty=1, full=0, err=0
  - op_ready=1, FSM=IDLE
- RAM contents are not reset.
- Reset asserted during PUSH2_B abandons the second half; the stack is empty after reset.
- Spill RAM: combinational read, one synchronous write port. At most one RAM write per cycle.

## Configuration
- `STACK_ERR_STICKY_EN` defined:
  - `err` stays high after any fault until `clr_err` or reset.
  - A fault in the same cycle as `clr_err` leaves `err`=1.
- `STACK_ERR_STICKY_EN` undefined: one-cycle pulse behaviour; `clr_err` has no effect.

## Structure
- Package `stack_pkg`:
  - `stack_op_t` enum with the eight opcodes;
  - FSM state typedef;
  - `STACK_DEFAULT_WIDTH`/`STACK_DEFAULT_DEPTH` constants.
- Sub-module `stack_spill_ram`:
  - DEPTH-2 by WIDTH;
  - one write port, one asynchronous read port;
  - instantiated once.

## Test plan
- Reset, then PUSH 1, PUSH 4 -> top=4, second=1, count=2, empty=0.
- PUSH2 getin=1, getin2=4 on empty stack -> op_ready=0 one cycle, then top=4, second=1, count=2.
- Push 5,6,7 then POP twice -> top=6/second=5, then top=5/second=0, count=1. Confirms spill readback and zero fill.
- Fill to DEPTH, then PUSH 9 -> err, full=1, contents unchanged. POP on empty -> err, count=0.
- With STACK_ERR_STICKY_EN: fault, then 3 legal ops -> err held 1; clr_err -> err=0. Without the macro, err=1 for exactly one cycle.
- Assert reset during PUSH2_B -> count=0, top=0, op_ready=1 immediately. A subsequent SWAP faults.
